// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_e : controller states (IDLE, RUN, DONE)
//   DIV_W       : default operand width
package div_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_i : W+1-bit partial remainder, already shifted left with the next dividend bit
//   div_i : W-bit divisor
//   rem_o : next partial remainder (always < divisor, so W bits suffice)
//   q_o   : quotient bit produced by this iteration
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic         ge;
    logic [W-1:0] diff;

    assign ge   = (rem_i >= {1'b0, div_i});
    // When ge holds the true difference is below the divisor, so the
    // W-bit modular subtraction already gives the exact result.
    assign diff = rem_i[W-1:0] - div_i;

    assign rem_o = ge ? diff : rem_i[W-1:0];
    assign q_o   = ge;

endmodule : div_step

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, dominates start
//   start : request, sampled only in IDLE or DONE
//   D, d  : dividend and divisor, captured on an accepted start
//   busy  : high while iterating
//   done  : one-cycle pulse when q/r/dz are valid
//   q, r  : quotient and remainder, updated only on entry to DONE
//   dz    : divide-by-zero flag (q = all ones, r = D when set)
module div_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] D,
    input  logic [W-1:0] d,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         dz
);

    localparam int CW = $clog2(W + 1);

    div_state_e   state_q;
    logic [CW-1:0] cnt_q;
    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after W iterations this register holds the full quotient.
    logic [W-1:0] work_q;
    logic [W-1:0] dvs_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] q_q;
    logic [W-1:0] r_q;
    logic         dz_q;
    logic         busy_q;
    logic         done_q;

    logic [W:0]   rem_shift_d;
    logic [W-1:0] rem_d;
    logic         qbit_d;
    logic [W-1:0] work_d;

    assign rem_shift_d = {rem_q, work_q[W-1]};
    assign work_d      = {work_q[W-2:0], qbit_d};

    div_step #(.W(W)) u_step (
        .rem_i (rem_shift_d),
        .div_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q <= D;
                        dvs_q  <= d;
                        rem_q  <= '0;
                        cnt_q  <= CW'(W);
                        if (d == '0) begin
                            // Divide by zero finishes immediately with a defined result.
                            state_q <= ST_DONE;
                            q_q     <= '1;
                            r_q     <= D;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                            dz_q    <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Last iteration: publish the result straight from the step.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        q_q     <= work_d;
                        r_q     <= rem_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule : div_seq
